stereo_tone_generator: RTL and testbench
========================================

// Module: stereo_tone_generator
// PURPOSE
//  Upstream audio source for the I2S sample FIFO: direct-digital-synthesis tone generator producing
//  one 48-bit stereo word {left,right} per handshake. Independent frequency per channel, common gain.
//  Sample rate is set by downstream back-pressure (FIFO full while I2S master drains at lrclk rate).
//  Replaces the fixed mono sine source; output drops straight onto the FIFO write port.
// PARAMETERS
//  PHASE_W  32  phase accumulator width per channel
//  LUT_AW   8   quarter-wave table address bits (2^LUT_AW entries)
//  DATA_W   24  sample width per channel, two's complement
// PORTS
//  clk        in   1         system clock
//  arst_n     in   1         asynchronous reset, active low
//  enable     in   1         run generator; low = stop after current word is accepted
//  freq_l     in   PHASE_W   left phase increment per sample (f = freq*fs/2^PHASE_W)
//  freq_r     in   PHASE_W   right phase increment per sample
//  gain       in   8         unsigned amplitude, 128 = unity, 0 = mute
//  out_data   out  2*DATA_W  {left,right} sample word
//  out_valid  out  1         out_data valid
//  out_ready  in   1         consumer accepts (connect !fifo_full)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, phase_l=phase_r=0, FSM=IDLE, latched freq/gain=0.
//  FSM: IDLE -> RD_L (enable=1; latch freq_l, freq_r, gain; ROM addr from phase_l)
//       RD_L -> RD_R (capture left ROM word; ROM addr from phase_r)
//       RD_R -> MUL  (capture right ROM word; both products registered)
//       MUL  -> OUT  (saturated results into out_data, out_valid=1)
//       OUT  -> RD_L on out_valid&out_ready if enable=1 (relatch inputs), else IDLE.
//  Latency: out_valid rises exactly 4 cycles after leaving IDLE; max throughput 1 word / 4 cycles.
//  Handshake: transfer when out_valid&out_ready at rising clk. While out_valid=1 and not accepted,
//   out_data is stable and phases do not advance. out_valid never drops without a transfer.
//  Phase: on transfer, phase_l += freq_l_latched, phase_r += freq_r_latched, modulo 2^PHASE_W (wrap silent).
//  Inputs freq/gain only sampled at latch points; changes mid-sample never tear a word.
//  enable low in OUT: pending word still completes handshake, then IDLE; phases retained (no reset).
//  Lookup: q=phase[MSB:MSB-1], i=phase[MSB-2 -: LUT_AW]; q=1,3 use ~i; q=2,3 negate ROM word.
//   ROM[k] = round((2^(DATA_W-1)-1)*sin(pi/2*(k+0.5)/2^LUT_AW)), positive, no entry equals 0.
//  Scale: y = (s*gain) >>> 7 (arithmetic), full-precision product DATA_W+9 bits;
//   saturate symmetric to +(2^(DATA_W-1)-1) / -(2^(DATA_W-1)-1); 0x800000 never emitted.
//  Async reset mid-operation: immediate return to reset state; in-flight word discarded.
// STRUCTURE
//  Shared package (audio_pkg): DATA_W, sample-word packing order {left,right}, gain unity constant,
//   FSM state encoding.
//  Sub-module quarter_sine_rom: LUT_AW address in, DATA_W registered data out, 1-cycle latency,
//   table generated at elaboration (initial block / function), infers BRAM or LUT ROM.
//  Top holds FSM, accumulators, sign/mirror logic, multiplier and saturation (one shared ROM, time-multiplexed).
// TESTING
//  1 Reset: arst_n=0 mid-OUT -> out_valid=0, out_data=0 same cycle; after release first word uses phase 0.
//  2 freq_l=freq_r=2^30, gain=128, ready=1 -> left sequence ROM[0], ROM[255]=0x7FFFD8, -ROM[0], -0x7FFFD8, repeats.
//  3 gain=255, freq_l=2^30 (2nd word) -> left=0x7FFFFF; 4th word -> 0x800001; gain=0 -> all words 0.
//  4 Back-pressure: out_ready=0 for 10 cycles while valid -> out_data stable, next word = phase+freq (no skip).
//  5 freq_l=0xFFFFFFFF -> phase wraps; left walks backwards through table; no glitch at wrap.
//  6 enable dropped during RD_R -> that word still delivered on ready, then out_valid=0 and FSM IDLE;
//    freq change while valid=1 -> takes effect only on following word.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared constants for the audio source path: sample width, gain
//            unity point and tone-generator state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Stereo words are packed {left, right}, left in the upper half.
    localparam int c_data_w = 24;

    localparam logic [7:0] c_gain_unity = 8'd128;
    localparam int         c_gain_shift = $clog2(c_gain_unity);

    localparam int                c_st_w    = 3;
    localparam logic [c_st_w-1:0] c_st_idle = 3'd0;
    localparam logic [c_st_w-1:0] c_st_rd_l = 3'd1;
    localparam logic [c_st_w-1:0] c_st_rd_r = 3'd2;
    localparam logic [c_st_w-1:0] c_st_mul  = 3'd3;
    localparam logic [c_st_w-1:0] c_st_out  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/quarter_sine_rom.sv
`default_nettype none
// ============================================================================
// Module   : quarter_sine_rom
// Purpose  : Quarter-wave sine magnitude table, registered output, 1-cycle
//            latency; contents computed at elaboration.
// Revision : 1.0 - initial release
// ============================================================================
module quarter_sine_rom #(
    parameter int LUT_AW = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    localparam int  c_depth   = 2**LUT_AW;
    localparam real c_half_pi = 1.5707963267948966;

    // Taylor series keeps the table independent of tool math-library support.
    function automatic logic [DATA_W-1:0] sine_entry(input int k);
        real x;
        real term;
        real acc;
        x    = c_half_pi * ($itor(k) + 0.5) / $itor(c_depth);
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return DATA_W'($rtoi(acc * $itor(2**(DATA_W-1) - 1) + 0.5));
    endfunction

    logic [DATA_W-1:0] w_table [c_depth];
    logic [DATA_W-1:0] r_data;

    for (genvar k = 0; k < c_depth; k++) begin : g_table
        localparam logic [DATA_W-1:0] c_entry = sine_entry(k);
        assign w_table[k] = c_entry;
    end

    always_ff @(posedge clk) begin
        r_data <= w_table[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/stereo_tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : stereo_tone_generator
// Purpose  : Two-channel DDS tone source with common gain, one {left,right}
//            word per valid/ready handshake; shares a single sine ROM.
// Revision : 1.0 - initial release
// ============================================================================
module stereo_tone_generator
    import audio_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = c_data_w
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                enable,
    input  logic [PHASE_W-1:0]  freq_l,
    input  logic [PHASE_W-1:0]  freq_r,
    input  logic [7:0]          gain,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int c_prod_w = DATA_W + 9;
    localparam logic signed [c_prod_w-1:0] c_pos_max = c_prod_w'(2**(DATA_W-1) - 1);
    localparam logic signed [c_prod_w-1:0] c_neg_max = -c_pos_max;

    logic [c_st_w-1:0]          r_state;
    logic [c_st_w-1:0]          w_state_next;
    logic [PHASE_W-1:0]         r_phase_l;
    logic [PHASE_W-1:0]         r_phase_r;
    logic [PHASE_W-1:0]         r_freq_l;
    logic [PHASE_W-1:0]         r_freq_r;
    logic [PHASE_W-1:0]         w_phase_l_next;
    logic [PHASE_W-1:0]         w_phase_r_next;
    logic [7:0]                 r_gain;
    logic                       w_xfer;
    logic                       w_latch;
    logic [LUT_AW:0]            w_rd_top;
    logic [LUT_AW-1:0]          w_rom_addr;
    logic [DATA_W-1:0]          w_rom_data;
    logic signed [DATA_W-1:0]   w_samp_l;
    logic signed [DATA_W-1:0]   w_samp_r;
    logic signed [DATA_W-1:0]   r_samp_l;
    logic signed [8:0]          w_gain_s;
    logic signed [c_prod_w-1:0] r_prod_l;
    logic signed [c_prod_w-1:0] r_prod_r;
    logic [2*DATA_W-1:0]        r_out_data;
    logic                       r_out_valid;

    function automatic logic signed [DATA_W-1:0] apply_sign(
        input logic [DATA_W-1:0] mag,
        input logic              neg
    );
        return neg ? -mag : mag;
    endfunction

    // Symmetric clamp so the most negative code is never produced.
    function automatic logic [DATA_W-1:0] scale_sat(input logic signed [c_prod_w-1:0] p);
        logic signed [c_prod_w-1:0] y;
        y = p >>> c_gain_shift;
        if (y > c_pos_max) begin
            y = c_pos_max;
        end else if (y < c_neg_max) begin
            y = c_neg_max;
        end
        return DATA_W'(y);
    endfunction

    assign w_xfer         = r_out_valid & out_ready;
    assign w_latch        = enable & ((r_state == c_st_idle) ||
                                      ((r_state == c_st_out) && w_xfer));
    assign w_phase_l_next = r_phase_l + r_freq_l;
    assign w_phase_r_next = r_phase_r + r_freq_r;

    // ROM address is issued one state ahead; in OUT it already targets the
    // phase the next word will use, so the table read overlaps the handshake.
    always_comb begin
        w_rd_top = r_phase_r[PHASE_W-2 -: LUT_AW+1];
        case (r_state)
            c_st_idle: w_rd_top = r_phase_l[PHASE_W-2 -: LUT_AW+1];
            c_st_out:  w_rd_top = w_phase_l_next[PHASE_W-2 -: LUT_AW+1];
            default:   w_rd_top = r_phase_r[PHASE_W-2 -: LUT_AW+1];
        endcase
    end

    assign w_rom_addr = w_rd_top[LUT_AW] ? ~w_rd_top[LUT_AW-1:0] : w_rd_top[LUT_AW-1:0];

    quarter_sine_rom #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    assign w_samp_l = apply_sign(w_rom_data, r_phase_l[PHASE_W-1]);
    assign w_samp_r = apply_sign(w_rom_data, r_phase_r[PHASE_W-1]);
    assign w_gain_s = $signed({1'b0, r_gain});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (enable) w_state_next = c_st_rd_l;
            c_st_rd_l: w_state_next = c_st_rd_r;
            c_st_rd_r: w_state_next = c_st_mul;
            c_st_mul:  w_state_next = c_st_out;
            c_st_out:  if (w_xfer) w_state_next = enable ? c_st_rd_l : c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_freq_l  <= '0;
            r_freq_r  <= '0;
            r_gain    <= '0;
            r_phase_l <= '0;
            r_phase_r <= '0;
        end else begin
            if (w_latch) begin
                r_freq_l <= freq_l;
                r_freq_r <= freq_r;
                r_gain   <= gain;
            end
            if ((r_state == c_st_out) && w_xfer) begin
                r_phase_l <= w_phase_l_next;
                r_phase_r <= w_phase_r_next;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_samp_l    <= '0;
            r_prod_l    <= '0;
            r_prod_r    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == c_st_rd_l) begin
                r_samp_l <= w_samp_l;
            end
            if (r_state == c_st_rd_r) begin
                r_prod_l <= c_prod_w'(r_samp_l) * c_prod_w'(w_gain_s);
                r_prod_r <= c_prod_w'(w_samp_r) * c_prod_w'(w_gain_s);
            end
            if (r_state == c_st_mul) begin
                r_out_data  <= {scale_sat(r_prod_l), scale_sat(r_prod_r)};
                r_out_valid <= 1'b1;
            end else if ((r_state == c_st_out) && w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stereo_tone_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_stereo_tone_generator
// Purpose  : Directed self-checking bench for stereo_tone_generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stereo_tone_generator;

    localparam logic [23:0] c_r0    = 24'h006488;  // ROM[0]
    localparam logic [23:0] c_r255  = 24'h7FFFD8;  // ROM[255]
    localparam logic [23:0] c_nr0   = 24'hFF9B78;  // -ROM[0]
    localparam logic [23:0] c_nr255 = 24'h800028;  // -ROM[255]
    localparam logic [23:0] c_g0    = 24'h00C846;  // (ROM[0]*255)>>>7
    localparam logic [23:0] c_ng0   = 24'hFF37B9;  // (-ROM[0]*255)>>>7
    localparam logic [23:0] c_pmax  = 24'h7FFFFF;
    localparam logic [23:0] c_nmax  = 24'h800001;
    localparam logic [31:0] c_quart = 32'h4000_0000;

    logic        clk;
    logic        arst_n;
    logic        enable;
    logic [31:0] freq_l;
    logic [31:0] freq_r;
    logic [7:0]  gain;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    stereo_tone_generator dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .enable    (enable),
        .freq_l    (freq_l),
        .freq_r    (freq_r),
        .gain      (gain),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
    endtask

    task automatic wait_word(input string tag, input logic [23:0] exp_l,
                             input logic [23:0] exp_r, output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 16) begin
            step();
            cycles++;
        end
        chk({tag, "_valid"}, {47'd0, out_valid}, 48'd1);
        chk(tag, out_data, {exp_l, exp_r});
    endtask

    initial begin
        int cyc;
        int bad;

        arst_n    = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b1;
        freq_l    = '0;
        freq_r    = '0;
        gain      = '0;
        repeat (3) step();
        chk("rst_valid", {47'd0, out_valid}, 48'd0);
        chk("rst_data", out_data, 48'd0);

        // Quarter-turn steps at unity gain
        freq_l = c_quart;
        freq_r = c_quart;
        gain   = 8'd128;
        enable = 1'b1;
        step();
        arst_n = 1'b1;
        repeat (3) begin
            step();
            chk("latency_low", {47'd0, out_valid}, 48'd0);
        end
        wait_word("t2_w1", c_r0, c_r0, cyc);
        chk("latency_edge", 48'(cyc), 48'd1);
        take();
        wait_word("t2_w2", c_r255, c_r255, cyc);
        chk("throughput", 48'(cyc), 48'd3);
        take();
        wait_word("t2_w3", c_nr0, c_nr0, cyc);
        take();
        wait_word("t2_w4", c_nr255, c_nr255, cyc);
        take();
        wait_word("t2_w5", c_r0, c_r0, cyc);
        take();

        // Back-pressure holds the word and the phase
        out_ready = 1'b0;
        wait_word("bp_w6", c_r255, c_r255, cyc);
        bad = 0;
        repeat (10) begin
            step();
            if (out_valid !== 1'b1 || out_data !== {c_r255, c_r255}) bad++;
        end
        chk("bp_hold", 48'(bad), 48'd0);
        take();
        wait_word("bp_w7", c_nr0, c_nr0, cyc);
        take();

        // Asynchronous reset while a word is pending
        out_ready = 1'b0;
        wait_word("t1_w8", c_nr255, c_nr255, cyc);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_valid", {47'd0, out_valid}, 48'd0);
        chk("arst_data", out_data, 48'd0);

        // Gain 255 saturation, then mute
        gain      = 8'd255;
        freq_l    = c_quart;
        freq_r    = 32'd0;
        out_ready = 1'b1;
        step();
        arst_n = 1'b1;
        wait_word("t3_w1", c_g0, c_g0, cyc);
        take();
        wait_word("t3_w2", c_pmax, c_g0, cyc);
        take();
        wait_word("t3_w3", c_ng0, c_g0, cyc);
        take();
        wait_word("t3_w4", c_nmax, c_g0, cyc);
        take();
        gain = 8'd0;
        wait_word("t3_w5", c_g0, c_g0, cyc);
        take();
        wait_word("t3_w6", 24'd0, 24'd0, cyc);
        take();
        wait_word("t3_w7", 24'd0, 24'd0, cyc);
        take();

        // Backward phase walk through the wrap point
        arst_n = 1'b0;
        freq_l = 32'hFFFF_FFFF;
        freq_r = c_quart;
        gain   = 8'd128;
        repeat (2) step();
        arst_n = 1'b1;
        wait_word("t5_w1", c_r0, c_r0, cyc);
        take();
        wait_word("t5_w2", c_nr0, c_r255, cyc);
        take();
        wait_word("t5_w3", c_nr0, c_nr0, cyc);
        take();

        // Enable dropped mid-word
        step();
        enable = 1'b0;
        wait_word("t6_w4", c_nr0, c_nr255, cyc);
        take();
        bad = 0;
        repeat (8) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        chk("t6_idle", 48'(bad), 48'd0);

        // Frequency change while valid applies one word later
        out_ready = 1'b0;
        freq_l    = 32'd0;
        freq_r    = 32'd0;
        enable    = 1'b1;
        wait_word("t6_w5", c_nr0, c_r0, cyc);
        freq_l = c_quart;
        freq_r = c_quart;
        take();
        wait_word("t6_w6", c_nr0, c_r0, cyc);
        take();
        wait_word("t6_w7", c_r255, c_r255, cyc);
        take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
